// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/peripheral bus.
// Each master request is held in a register, then issued downstream one transaction at a time.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus free; a pending request (if any) is granted and issued now
// READ_WAIT | read issued; counting down READ_LAT cycles to capture s_rdata
module mem_bus_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT);

  state_t      state;
  logic [1:0]  pending;
  logic [1:0]  is_read;
  logic [31:0] lat_addr  [2];
  logic [31:0] lat_wdata [2];
  logic [3:0]  lat_wmask [2];
  logic        last_grant;
  logic        cur;
  logic [2:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q [2];

  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic [1:0]  req_rstrb;
  logic [1:0]  wr_req;
  logic [1:0]  rd_req;
  logic [1:0]  accept;
  logic        gnt;
  logic        issue;

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_rstrb    = {m1_rstrb, m0_rstrb};

  // A write strobe wins over a simultaneous read strobe.
  always_comb begin
    wr_req = '0;
    rd_req = '0;
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      wr_req[i] = |req_wmask[i];
      rd_req[i] = req_rstrb[i] & ~wr_req[i];
      accept[i] = ~reset & ~pending[i] & (req_rstrb[i] | wr_req[i]);
    end
  end

  assign gnt   = (&pending) ? ~last_grant : pending[1];
  assign issue = ~reset & (state == IDLE) & (|pending);

  // The grant cycle is the issue cycle, so the bus side is driven straight from the holding registers.
  assign s_addr  = issue ? lat_addr[gnt]  : addr_q;
  assign s_wdata = issue ? lat_wdata[gnt] : wdata_q;
  assign s_rstrb = issue & is_read[gnt];
  assign s_wmask = (issue & ~is_read[gnt]) ? lat_wmask[gnt] : 4'h0;

  assign m0_rbusy = ~reset & ((pending[0] & is_read[0])  | (rd_req[0] & ~pending[0]));
  assign m0_wbusy = ~reset & ((pending[0] & ~is_read[0]) | (wr_req[0] & ~pending[0]));
  assign m1_rbusy = ~reset & ((pending[1] & is_read[1])  | (rd_req[1] & ~pending[1]));
  assign m1_wbusy = ~reset & ((pending[1] & ~is_read[1]) | (wr_req[1] & ~pending[1]));

  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      is_read    <= '0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        lat_addr[i]  <= '0;
        lat_wdata[i] <= '0;
        lat_wmask[i] <= '0;
        rdata_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          lat_addr[i]  <= req_addr[i];
          lat_wdata[i] <= req_wdata[i];
          lat_wmask[i] <= req_wmask[i];
          is_read[i]   <= ~wr_req[i];
          pending[i]   <= 1'b1;
        end
      end
      // Accept only touches idle masters, clears below only touch pending ones.
      case (state)
        IDLE: begin
          if (|pending) begin
            last_grant <= gnt;
            addr_q     <= lat_addr[gnt];
            wdata_q    <= lat_wdata[gnt];
            if (is_read[gnt]) begin
              cur   <= gnt;
              cnt   <= CNT_INIT;
              state <= READ_WAIT;
            end else begin
              pending[gnt] <= 1'b0;
            end
          end
        end
        READ_WAIT: begin
          if (cnt == 3'd1) begin
            rdata_q[cur] <= s_rdata;
            pending[cur] <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (READ_LAT 1 and 3) share the master stimulus,
// each with its own latency-accurate memory and a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wmask [2];
  logic        m_rstrb [2];

  logic [31:0] o_rdata [2][2];
  logic        o_rbusy [2][2];
  logic        o_wbusy [2][2];
  logic [31:0] o_saddr  [2];
  logic [31:0] o_swdata [2];
  logic [3:0]  o_swmask [2];
  logic        o_srstrb [2];
  logic [31:0] i_srdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_bus_arbiter #(.READ_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]), .m0_rstrb(m_rstrb[0]),
    .m0_rdata(o_rdata[0][0]), .m0_rbusy(o_rbusy[0][0]), .m0_wbusy(o_wbusy[0][0]),
    .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]), .m1_rstrb(m_rstrb[1]),
    .m1_rdata(o_rdata[0][1]), .m1_rbusy(o_rbusy[0][1]), .m1_wbusy(o_wbusy[0][1]),
    .s_addr(o_saddr[0]), .s_wdata(o_swdata[0]), .s_wmask(o_swmask[0]), .s_rstrb(o_srstrb[0]),
    .s_rdata(i_srdata[0])
  );

  mem_bus_arbiter #(.READ_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]), .m0_rstrb(m_rstrb[0]),
    .m0_rdata(o_rdata[1][0]), .m0_rbusy(o_rbusy[1][0]), .m0_wbusy(o_wbusy[1][0]),
    .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]), .m1_rstrb(m_rstrb[1]),
    .m1_rdata(o_rdata[1][1]), .m1_rbusy(o_rbusy[1][1]), .m1_wbusy(o_wbusy[1][1]),
    .s_addr(o_saddr[1]), .s_wdata(o_swdata[1]), .s_wmask(o_swmask[1]), .s_rstrb(o_srstrb[1]),
    .s_rdata(i_srdata[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h13579BDF);
  endfunction

  // Memory: data for a strobed address is valid exactly READ_LAT cycles after the strobe, junk otherwise.
  logic [7:0]  vpipe [2] = '{8'h00, 8'h00};
  logic [31:0] apipe [2][8];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      vpipe[k]    <= {vpipe[k][6:0], o_srstrb[k]};
      apipe[k][0] <= o_saddr[k];
      for (int j = 1; j < 8; j++) apipe[k][j] <= apipe[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      i_srdata[k] = 32'hBAD00000 ^ 32'(cyc);
      if (vpipe[k][lat_of(k)-1] === 1'b1) i_srdata[k] = mem_f(apipe[k][lat_of(k)-1]);
    end
  end

  // Reference model state, per instance k and master m.
  bit          pend   [2][2];
  bit          isrd   [2][2];
  logic [31:0] laddr  [2][2];
  logic [31:0] lwdata [2][2];
  logic [3:0]  lwmask [2][2];
  bit          rd_act [2];
  int          rd_cap [2];
  int          rd_m   [2];
  int          last   [2];
  logic [31:0] exp_rdata  [2][2];
  logic [31:0] hold_addr  [2];
  logic [31:0] hold_wdata [2];

  // Per-cycle logs for the directed timing checks.
  logic        lg_rs [2][1024];
  logic [31:0] lg_sa [2][1024];
  logic [3:0]  lg_wm [1024];
  logic [31:0] lg_sd [1024];
  logic        lg_rb [2][2][1024];
  logic        lg_wb [1024];
  logic [31:0] lg_rd [2][2][1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        pend[k][m] = 0; isrd[k][m] = 0;
        laddr[k][m] = '0; lwdata[k][m] = '0; lwmask[k][m] = '0;
        exp_rdata[k][m] = '0;
      end
      rd_act[k] = 0; rd_cap[k] = 0; rd_m[k] = 0; last[k] = 1;
      hold_addr[k] = '0; hold_wdata[k] = '0;
    end
  endtask

  task automatic model_cycle(input int k);
    bit          acc [2];
    bit          e_rs;
    logic [3:0]  e_wm;
    logic [31:0] e_a, e_d;
    int          g;
    for (int m = 0; m < 2; m++) begin
      acc[m] = !pend[k][m] && (m_rstrb[m] || m_wmask[m] != 0);
      chk($sformatf("rbusy_k%0d_m%0d", k, m), o_rbusy[k][m],
          (pend[k][m] && isrd[k][m]) || (m_rstrb[m] && !pend[k][m] && m_wmask[m] == 0));
      chk($sformatf("wbusy_k%0d_m%0d", k, m), o_wbusy[k][m],
          (pend[k][m] && !isrd[k][m]) || (m_wmask[m] != 0 && !pend[k][m]));
      chk($sformatf("rdata_k%0d_m%0d", k, m), o_rdata[k][m], exp_rdata[k][m]);
    end
    e_rs = 0; e_wm = 0; e_a = hold_addr[k]; e_d = hold_wdata[k];
    if (rd_act[k]) begin
      if (cyc == rd_cap[k]) begin
        exp_rdata[k][rd_m[k]] = mem_f(hold_addr[k]);
        pend[k][rd_m[k]] = 0;
        rd_act[k] = 0;
      end
    end else if (pend[k][0] || pend[k][1]) begin
      g = (pend[k][0] && pend[k][1]) ? 1 - last[k] : (pend[k][1] ? 1 : 0);
      last[k] = g;
      e_a = laddr[k][g]; e_d = lwdata[k][g];
      hold_addr[k] = e_a; hold_wdata[k] = e_d;
      if (isrd[k][g]) begin
        e_rs = 1; rd_act[k] = 1; rd_cap[k] = cyc + lat_of(k); rd_m[k] = g;
      end else begin
        e_wm = lwmask[k][g]; pend[k][g] = 0;
      end
    end
    chk($sformatf("s_rstrb_k%0d", k), o_srstrb[k], e_rs);
    chk($sformatf("s_wmask_k%0d", k), o_swmask[k], e_wm);
    chk($sformatf("s_addr_k%0d", k), o_saddr[k], e_a);
    chk($sformatf("s_wdata_k%0d", k), o_swdata[k], e_d);
    for (int m = 0; m < 2; m++) begin
      if (acc[m]) begin
        laddr[k][m] = m_addr[m]; lwdata[k][m] = m_wdata[m]; lwmask[k][m] = m_wmask[m];
        isrd[k][m] = (m_wmask[m] == 0); pend[k][m] = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (cyc < 1024) begin
      lg_wm[cyc] = o_swmask[0]; lg_sd[cyc] = o_swdata[0]; lg_wb[cyc] = o_wbusy[0][0];
      for (int k = 0; k < 2; k++) begin
        lg_rs[k][cyc] = o_srstrb[k]; lg_sa[k][cyc] = o_saddr[k];
        for (int m = 0; m < 2; m++) begin
          lg_rb[k][m][cyc] = o_rbusy[k][m]; lg_rd[k][m][cyc] = o_rdata[k][m];
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("rst_rbusy_k%0d_m%0d", k, m), o_rbusy[k][m], 0);
          chk($sformatf("rst_wbusy_k%0d_m%0d", k, m), o_wbusy[k][m], 0);
        end
        chk($sformatf("rst_s_rstrb_k%0d", k), o_srstrb[k], 0);
        chk($sformatf("rst_s_wmask_k%0d", k), o_swmask[k], 0);
      end else begin
        model_cycle(k);
      end
    end
    if (reset) model_reset();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    for (int m = 0; m < 2; m++) begin m_rstrb[m] = 0; m_wmask[m] = 0; end
  endtask

  task automatic rd(input int m, input logic [31:0] a);
    m_rstrb[m] = 1; m_wmask[m] = 0; m_addr[m] = a;
  endtask

  task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
    m_rstrb[m] = 0; m_wmask[m] = mk; m_addr[m] = a; m_wdata[m] = d;
  endtask

  task automatic do_reset();
    reset = 1; idle_in(); step(); reset = 0;
  endtask

  int b;
  int r;

  initial begin
    for (int m = 0; m < 2; m++) begin m_addr[m] = '0; m_wdata[m] = '0; end
    idle_in();
    model_reset();
    reset = 1; step(); step(); reset = 0;

    // Uncontended read of 0x10
    b = cyc; rd(0, 32'h10); step(); idle_in(); repeat (5) step();
    chk("t1_rs_c0", lg_rs[0][b], 0);
    chk("t1_rs_c1", lg_rs[0][b+1], 1);
    chk("t1_rs_c2", lg_rs[0][b+2], 0);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_rbusy_c%0d", i), lg_rb[0][0][b+i], 1);
    chk("t1_rbusy_c3", lg_rb[0][0][b+3], 0);
    chk("t1_rdata_c2", lg_rd[0][0][b+2], 0);
    chk("t1_rdata_c3", lg_rd[0][0][b+3], 32'hDEADBEEF);
    chk("t1_m1_rdata_c3", lg_rd[0][1][b+3], 0);
    chk("t1_m1_rbusy_c1", lg_rb[0][1][b+1], 0);
    chk("t1_l3_rdata_c4", lg_rd[1][0][b+4], 0);
    chk("t1_l3_rdata_c5", lg_rd[1][0][b+5], 32'hDEADBEEF);

    // Uncontended write
    b = cyc; wr(0, 32'h00400000, 32'h41, 4'hF); step(); idle_in(); repeat (3) step();
    chk("t2_wmask_c0", lg_wm[b], 0);
    chk("t2_wmask_c1", lg_wm[b+1], 4'hF);
    chk("t2_wmask_c2", lg_wm[b+2], 0);
    chk("t2_addr_c1", lg_sa[0][b+1], 32'h00400000);
    chk("t2_wdata_c1", lg_sd[b+1], 32'h41);
    chk("t2_wbusy_c0", lg_wb[b], 1);
    chk("t2_wbusy_c1", lg_wb[b+1], 1);
    chk("t2_wbusy_c2", lg_wb[b+2], 0);

    // Simultaneous reads, then a tie that must go to master 0
    do_reset();
    b = cyc; rd(0, 32'h20); rd(1, 32'h24); step(); idle_in(); repeat (5) step();
    wr(0, 32'h50, 32'h1, 4'h3); wr(1, 32'h54, 32'h2, 4'hC); step(); idle_in(); repeat (6) step();
    chk("t3_rs_c1", lg_rs[0][b+1], 1);
    chk("t3_rs_c2", lg_rs[0][b+2], 0);
    chk("t3_rs_c3", lg_rs[0][b+3], 1);
    chk("t3_addr_c3", lg_sa[0][b+3], 32'h24);
    chk("t3_m0_rdata_c3", lg_rd[0][0][b+3], mem_f(32'h20));
    chk("t3_m1_rdata_c4", lg_rd[0][1][b+4], 0);
    chk("t3_m1_rdata_c5", lg_rd[0][1][b+5], mem_f(32'h24));
    chk("t3_tie_c7", lg_sa[0][b+7], 32'h50);
    chk("t3_tie_c8", lg_sa[0][b+8], 32'h54);

    // Back-to-back writes from both masters alternate with no gaps
    do_reset();
    b = cyc;
    for (int i = 0; i < 8; i++) begin
      wr(0, 32'h000A0000, 32'(i), 4'hF); wr(1, 32'h000B0000, 32'(i + 100), 4'hF); step();
    end
    idle_in(); repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_grant_%0d", i), lg_sa[0][b+1+i], (i % 2 == 0) ? 32'h000A0000 : 32'h000B0000);
      chk($sformatf("t4_wmask_%0d", i), lg_wm[b+1+i], 4'hF);
    end

    // READ_LAT = 3 read from master 1
    do_reset();
    b = cyc; rd(1, 32'h300); step(); idle_in(); repeat (6) step();
    chk("t5_rs_c1", lg_rs[1][b+1], 1);
    for (int i = 1; i < 5; i++) chk($sformatf("t5_addr_c%0d", i), lg_sa[1][b+i], 32'h300);
    chk("t5_rbusy_c4", lg_rb[1][1][b+4], 1);
    chk("t5_rbusy_c5", lg_rb[1][1][b+5], 0);
    chk("t5_rdata_c4", lg_rd[1][1][b+4], 0);
    chk("t5_rdata_c5", lg_rd[1][1][b+5], mem_f(32'h300));

    // Reset during READ_WAIT discards the read
    do_reset();
    b = cyc; rd(0, 32'h44); step(); idle_in(); step();
    reset = 1; step(); reset = 0;
    step();
    rd(0, 32'h48); step(); idle_in(); repeat (6) step();
    chk("t6_rbusy_c3", lg_rb[0][0][b+3], 0);
    chk("t6_rdata_c3", lg_rd[0][0][b+3], 0);
    chk("t6_rs_c3", lg_rs[0][b+3], 0);
    chk("t6_l3_stale_c5", lg_rd[1][0][b+5], 0);
    chk("t6_rs_c5", lg_rs[0][b+5], 1);
    chk("t6_rdata_c7", lg_rd[0][0][b+7], mem_f(32'h48));
    chk("t6_l3_rs_c5", lg_rs[1][b+5], 1);
    chk("t6_l3_rdata_c8", lg_rd[1][0][b+8], 0);
    chk("t6_l3_rdata_c9", lg_rd[1][0][b+9], mem_f(32'h48));

    // Random traffic, occasional resets, checked every cycle by the model
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        r = $urandom_range(0, 9);
        m_rstrb[m] = (r < 3) || (r == 9);
        m_wmask[m] = ((r >= 3 && r < 6) || r == 9) ? 4'($urandom_range(1, 15)) : 4'h0;
        m_addr[m]  = $urandom;
        m_wdata[m] = $urandom;
      end
      step();
    end
    reset = 0; idle_in(); repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
